// File: rtl/memory_stage.sv
// MEM pipeline stage: issues the data-bus request, waits on the two-phase
// handshake, formats load data and registers the result into MEM/WB.
module memory_stage #(
  parameter int XLEN   = 64,
  parameter int REGIDX = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              e_valid,
  input  logic              e_regwrite,
  input  logic              e_memtoreg,
  input  logic              e_memread,
  input  logic              e_memwrite,
  input  logic [XLEN-1:0]   e_aluout,
  input  logic [XLEN-1:0]   e_writedata,
  input  logic [2:0]        e_funct3,
  input  logic [XLEN-1:0]   e_pc,
  input  logic [REGIDX-1:0] e_dst,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              stallM,
  output logic [XLEN-1:0]   memdata,
  output logic              w_valid,
  output logic              w_regwrite,
  output logic [REGIDX-1:0] w_dst,
  output logic [XLEN-1:0]   w_result,
  output logic [XLEN-1:0]   w_pc,
  output logic              w_misalign
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          stateReg, stateNext;
  logic [2:0]      byteOff;
  logic [1:0]      accSize;
  logic            isMemAccess;
  logic            misalign;
  logic            memop;
  logic            ackBoth;
  logic            reqValid;
  logic            complete;
  logic            stall;
  logic [7:0]      sizeMask;
  logic [7:0]      laneStrobe;
  logic [XLEN-1:0] loadShifted;
  logic [XLEN-1:0] loadFmt;
  logic [XLEN-1:0] lastLoadReg;

  assign byteOff     = e_aluout[2:0];
  assign accSize     = e_funct3[1:0];
  assign isMemAccess = e_valid & (e_memread | e_memwrite);
  assign ackBoth     = dresp_addr_ok & dresp_data_ok;

  always_comb begin
    misalign = 1'b0;
    case (accSize)
      2'd1:    misalign = isMemAccess & byteOff[0];
      2'd2:    misalign = isMemAccess & (byteOff[1:0] != 2'b00);
      2'd3:    misalign = isMemAccess & (byteOff != 3'b000);
      default: misalign = 1'b0;
    endcase
  end

  assign memop = isMemAccess & ~misalign;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stateReg <= IDLE;
    else         stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    reqValid  = 1'b0;
    complete  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (memop) begin
          reqValid = 1'b1;
          if (ackBoth)            complete  = 1'b1;
          else if (dresp_addr_ok) stateNext = DATA;
          else                    stateNext = ADDR;
        end
      end
      ADDR: begin
        reqValid = 1'b1;
        if (ackBoth) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end else if (dresp_addr_ok) begin
          stateNext = DATA;
        end
      end
      DATA: begin
        if (dresp_data_ok) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    stall = ((stateReg != IDLE) | memop) & ~complete;
  end

  // Gated by resetn so both read 0 for the whole time reset is asserted.
  assign dreq_valid = reqValid & resetn;
  assign stallM     = stall & resetn;

  always_comb begin
    sizeMask = 8'h01;
    case (accSize)
      2'd0:    sizeMask = 8'h01;
      2'd1:    sizeMask = 8'h03;
      2'd2:    sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
  end

  assign laneStrobe  = sizeMask << byteOff;
  assign dreq_addr   = e_aluout;
  assign dreq_size   = {1'b0, accSize};
  assign dreq_strobe = e_memwrite ? laneStrobe : 8'h00;
  assign dreq_data   = e_writedata << {byteOff, 3'b000};

  assign loadShifted = dresp_data >> {byteOff, 3'b000};

  always_comb begin
    loadFmt = loadShifted;
    case (accSize)
      2'd0: loadFmt = {{(XLEN-8){~e_funct3[2] & loadShifted[7]}}, loadShifted[7:0]};
      2'd1: loadFmt = {{(XLEN-16){~e_funct3[2] & loadShifted[15]}}, loadShifted[15:0]};
      2'd2: loadFmt = {{(XLEN-32){~e_funct3[2] & loadShifted[31]}}, loadShifted[31:0]};
      default: loadFmt = loadShifted;
    endcase
  end

  // Outside the completion cycle the forwarding path replays the last load.
  assign memdata = (complete & e_memread) ? loadFmt : lastLoadReg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  lastLoadReg <= '0;
    else if (complete & e_memread) lastLoadReg <= loadFmt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_valid    <= 1'b0;
      w_regwrite <= 1'b0;
      w_dst      <= '0;
      w_result   <= '0;
      w_pc       <= '0;
      w_misalign <= 1'b0;
    end else if (!stall) begin
      w_valid    <= e_valid;
      w_regwrite <= e_regwrite & ~misalign;
      w_dst      <= e_dst;
      w_result   <= e_memtoreg ? memdata : e_aluout;
      w_pc       <= e_pc;
      w_misalign <= misalign;
    end else begin
      w_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: drives inputs just after posedge,
// checks combinational outputs at negedge and registered outputs after posedge.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        e_valid, e_regwrite, e_memtoreg, e_memread, e_memwrite;
  logic [63:0] e_aluout, e_writedata, e_pc;
  logic [2:0]  e_funct3;
  logic [4:0]  e_dst;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stallM;
  logic [63:0] memdata;
  logic        w_valid, w_regwrite, w_misalign;
  logic [4:0]  w_dst;
  logic [63:0] w_result, w_pc;

  int nCompared   = 0;
  int nMismatched = 0;

  memory_stage #(.XLEN(64), .REGIDX(5)) dut (
    .clk(clk), .resetn(resetn),
    .e_valid(e_valid), .e_regwrite(e_regwrite), .e_memtoreg(e_memtoreg),
    .e_memread(e_memread), .e_memwrite(e_memwrite), .e_aluout(e_aluout),
    .e_writedata(e_writedata), .e_funct3(e_funct3), .e_pc(e_pc), .e_dst(e_dst),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .stallM(stallM), .memdata(memdata),
    .w_valid(w_valid), .w_regwrite(w_regwrite), .w_dst(w_dst),
    .w_result(w_result), .w_pc(w_pc), .w_misalign(w_misalign)
  );

  always #5 clk = ~clk;

  task automatic setIdle();
    e_valid = 0; e_regwrite = 0; e_memtoreg = 0; e_memread = 0; e_memwrite = 0;
    e_aluout = 0; e_writedata = 0; e_funct3 = 0; e_pc = 0; e_dst = 0;
    dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 0;
    setIdle();
    #2;
    nCompared++; if (w_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_w_valid got=%0b exp=0", w_valid); end
    nCompared++; if (w_result !== 64'h0) begin nMismatched++; $display("FAIL reset_w_result got=%h exp=0", w_result); end
    nCompared++; if (dreq_valid !== 1'b0 || stallM !== 1'b0) begin nMismatched++; $display("FAIL reset_req_stall got=%0b%0b exp=00", dreq_valid, stallM); end
    nextCycle(); nextCycle();
    resetn = 1;
    nextCycle();
    $display("test_reset done");
  endtask

  task automatic test_alu();
    e_valid = 1; e_regwrite = 1; e_aluout = 64'h1234; e_dst = 5; e_pc = 64'h100;
    @(negedge clk);
    nCompared++; if (dreq_valid !== 1'b0 || stallM !== 1'b0) begin nMismatched++; $display("FAIL alu_req_stall got=%0b%0b exp=00", dreq_valid, stallM); end
    nextCycle();
    nCompared++; if (w_valid !== 1'b1 || w_regwrite !== 1'b1 || w_dst !== 5'd5) begin nMismatched++; $display("FAIL alu_ctrl got=%0b%0b dst=%0d exp=11 dst=5", w_valid, w_regwrite, w_dst); end
    nCompared++; if (w_result !== 64'h1234 || w_pc !== 64'h100) begin nMismatched++; $display("FAIL alu_result got=%h pc=%h exp=1234 pc=100", w_result, w_pc); end
    setIdle();
    $display("test_alu done");
  endtask

  task automatic test_lb();
    e_valid = 1; e_regwrite = 1; e_memtoreg = 1; e_memread = 1; e_funct3 = 3'd0;
    e_aluout = 64'h1003; e_dst = 7; e_pc = 64'h200;
    dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'h00000000_80000000;
    @(negedge clk);
    nCompared++; if (dreq_valid !== 1'b1 || stallM !== 1'b0) begin nMismatched++; $display("FAIL lb_req_stall got=%0b%0b exp=10", dreq_valid, stallM); end
    nCompared++; if (dreq_strobe !== 8'h00 || dreq_size !== 3'd0 || dreq_addr !== 64'h1003) begin nMismatched++; $display("FAIL lb_fields got=%h %0d %h exp=00 0 1003", dreq_strobe, dreq_size, dreq_addr); end
    nCompared++; if (memdata !== 64'hFFFF_FFFF_FFFF_FF80) begin nMismatched++; $display("FAIL lb_memdata got=%h exp=ffffffffffffff80", memdata); end
    nextCycle();
    nCompared++; if (w_result !== 64'hFFFF_FFFF_FFFF_FF80 || w_valid !== 1'b1) begin nMismatched++; $display("FAIL lb_w_result got=%h v=%0b exp=ffffffffffffff80 v=1", w_result, w_valid); end
    e_funct3 = 3'd4;
    nextCycle();
    nCompared++; if (w_result !== 64'h80) begin nMismatched++; $display("FAIL lbu_w_result got=%h exp=80", w_result); end
    setIdle();
    $display("test_lb done");
  endtask

  task automatic test_store_lanes();
    e_valid = 1; e_memwrite = 1; e_funct3 = 3'd0; e_aluout = 64'h6007; e_writedata = 64'hAB;
    dresp_addr_ok = 1; dresp_data_ok = 1;
    @(negedge clk);
    nCompared++; if (dreq_strobe !== 8'h80 || dreq_data !== 64'hAB00_0000_0000_0000 || stallM !== 1'b0) begin nMismatched++; $display("FAIL sb_lane got=%h %h s=%0b exp=80 ab00000000000000 s=0", dreq_strobe, dreq_data, stallM); end
    nextCycle();
    e_funct3 = 3'd1; e_aluout = 64'h6002; e_writedata = 64'h1234;
    @(negedge clk);
    nCompared++; if (dreq_strobe !== 8'h0C || dreq_data !== 64'h0000_0000_1234_0000 || dreq_size !== 3'd1) begin nMismatched++; $display("FAIL sh_lane got=%h %h %0d exp=0c 0000000012340000 1", dreq_strobe, dreq_data, dreq_size); end
    nextCycle();
    setIdle();
    $display("test_store_lanes done");
  endtask

  task automatic test_sw();
    for (int c = 0; c < 4; c++) begin
      e_valid = 1; e_memwrite = 1; e_funct3 = 3'd2; e_aluout = 64'h2004;
      e_writedata = 64'hDEADBEEF; e_pc = 64'h300;
      dresp_addr_ok = (c == 2); dresp_data_ok = (c == 3);
      @(negedge clk);
      nCompared++; if (stallM !== (c < 3) || dreq_valid !== (c < 3)) begin nMismatched++; $display("FAIL sw_stall_c%0d got=%0b%0b exp=%0b%0b", c, stallM, dreq_valid, c < 3, c < 3); end
      if (c < 3) begin
        nCompared++; if (dreq_strobe !== 8'hF0 || dreq_data !== 64'hDEADBEEF_00000000 || dreq_addr !== 64'h2004 || dreq_size !== 3'd2) begin nMismatched++; $display("FAIL sw_fields_c%0d got=%h %h %h %0d exp=f0 deadbeef00000000 2004 2", c, dreq_strobe, dreq_data, dreq_addr, dreq_size); end
      end
      nextCycle();
      nCompared++; if (w_valid !== (c == 3)) begin nMismatched++; $display("FAIL sw_w_valid_c%0d got=%0b exp=%0b", c, w_valid, c == 3); end
    end
    nCompared++; if (w_regwrite !== 1'b0 || w_pc !== 64'h300) begin nMismatched++; $display("FAIL sw_w_fields got=%0b %h exp=0 300", w_regwrite, w_pc); end
    setIdle();
    $display("test_sw done");
  endtask

  task automatic test_ld();
    for (int c = 0; c < 5; c++) begin
      e_valid = 1; e_regwrite = 1; e_memtoreg = 1; e_memread = 1; e_funct3 = 3'd3;
      e_aluout = 64'h3000; e_dst = 9; e_pc = 64'h400;
      dresp_addr_ok = (c == 0); dresp_data_ok = (c == 4);
      dresp_data = (c == 4) ? 64'h0123_4567_89AB_CDEF : 64'h5555_5555_5555_5555;
      @(negedge clk);
      nCompared++; if (dreq_valid !== (c == 0) || stallM !== (c != 4)) begin nMismatched++; $display("FAIL ld_req_c%0d got=%0b%0b exp=%0b%0b", c, dreq_valid, stallM, c == 0, c != 4); end
      if (c == 4) begin
        nCompared++; if (memdata !== 64'h0123_4567_89AB_CDEF) begin nMismatched++; $display("FAIL ld_memdata got=%h exp=0123456789abcdef", memdata); end
      end
      nextCycle();
      nCompared++; if (w_valid !== (c == 4)) begin nMismatched++; $display("FAIL ld_w_valid_c%0d got=%0b exp=%0b", c, w_valid, c == 4); end
    end
    nCompared++; if (w_result !== 64'h0123_4567_89AB_CDEF || w_dst !== 5'd9) begin nMismatched++; $display("FAIL ld_w_result got=%h dst=%0d exp=0123456789abcdef dst=9", w_result, w_dst); end
    setIdle();
    dresp_data = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    nCompared++; if (memdata !== 64'h0123_4567_89AB_CDEF) begin nMismatched++; $display("FAIL ld_memdata_hold got=%h exp=0123456789abcdef", memdata); end
    nextCycle();
    $display("test_ld done");
  endtask

  task automatic test_misalign();
    e_valid = 1; e_regwrite = 1; e_memtoreg = 1; e_memread = 1; e_funct3 = 3'd1;
    e_aluout = 64'h4001; e_dst = 3;
    @(negedge clk);
    nCompared++; if (dreq_valid !== 1'b0 || stallM !== 1'b0) begin nMismatched++; $display("FAIL lh_misalign_req got=%0b%0b exp=00", dreq_valid, stallM); end
    nextCycle();
    nCompared++; if (w_misalign !== 1'b1 || w_regwrite !== 1'b0 || w_valid !== 1'b1) begin nMismatched++; $display("FAIL lh_misalign_w got=%0b%0b%0b exp=101", w_misalign, w_regwrite, w_valid); end
    setIdle();
    nextCycle();
    $display("test_misalign done");
  endtask

  task automatic test_reset_mid();
    e_valid = 1; e_regwrite = 1; e_aluout = 64'hCAFE; e_pc = 64'h500; e_dst = 4;
    nextCycle();
    e_regwrite = 1; e_memtoreg = 1; e_memread = 1; e_funct3 = 3'd3;
    e_aluout = 64'h5000; e_pc = 64'h504; e_dst = 6; dresp_addr_ok = 1;
    nextCycle();
    dresp_addr_ok = 0;
    #2;
    nCompared++; if (stallM !== 1'b1 || dreq_valid !== 1'b0 || w_result !== 64'hCAFE) begin nMismatched++; $display("FAIL rmid_pre got=%0b%0b %h exp=10 cafe", stallM, dreq_valid, w_result); end
    resetn = 0;
    #1;
    nCompared++; if (w_valid !== 1'b0 || w_result !== 64'h0 || w_pc !== 64'h0 || w_dst !== 5'd0) begin nMismatched++; $display("FAIL rmid_w got=%0b %h %h %0d exp=0 0 0 0", w_valid, w_result, w_pc, w_dst); end
    nCompared++; if (dreq_valid !== 1'b0 || stallM !== 1'b0) begin nMismatched++; $display("FAIL rmid_req got=%0b%0b exp=00", dreq_valid, stallM); end
    setIdle();
    nextCycle();
    resetn = 1;
    dresp_data_ok = 1; dresp_data = 64'h7777;
    @(negedge clk);
    nCompared++; if (stallM !== 1'b0 || dreq_valid !== 1'b0) begin nMismatched++; $display("FAIL rmid_late_req got=%0b%0b exp=00", stallM, dreq_valid); end
    nextCycle();
    nCompared++; if (w_valid !== 1'b0) begin nMismatched++; $display("FAIL rmid_late_w_valid got=%0b exp=0", w_valid); end
    setIdle();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_store_lanes();
    test_sw();
    test_ld();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage. Consumes the execute-stage result bundle (ALU result, store data, memory controls, pc, dst) and issues the data-bus request.
- Waits on the data-bus handshake and formats load data. Registers the result into the MEM/WB boundary.
- Drives the MEMDATA forwarding value consumed by the execute-stage operand muxes, and the stall that freezes earlier stages.

Parameters:
- XLEN, 64, data/address width (word_t)
- REGIDX, 5, destination register index width

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- e_valid  in  1  execute bundle valid
- e_regwrite  in  1  writes a register
- e_memtoreg  in  1  result comes from memory
- e_memread  in  1  load
- e_memwrite  in  1  store
- e_aluout  in  XLEN  effective address or ALU result
- e_writedata  in  XLEN  store data, already forwarded
- e_funct3  in  3  instr[14:12], access size/sign
- e_pc  in  XLEN  instruction pc
- e_dst  in  REGIDX  destination register
- dreq_valid  out  1  bus request valid
- dreq_addr  out  XLEN  bus address
- dreq_size  out  3  0=byte, 1=half, 2=word, 3=dword
- dreq_strobe  out  8  byte write enables; 0 for loads
- dreq_data  out  XLEN  lane-aligned store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response complete
- dresp_data  in  XLEN  raw 8-byte-aligned read data
- stallM  out  1  freeze IF/ID/EX and hold e_* stable
- memdata  out  XLEN  formatted load data; forwarding source
- w_valid, w_regwrite  out  1 each  registered MEM/WB controls
- w_dst  out  REGIDX  registered destination
- w_result  out  XLEN  registered memdata or e_aluout
- w_pc  out  XLEN  registered pc
- w_misalign  out  1  registered misaligned-access flag

Behaviour:
- Reset (resetn=0, async):
  - FSM to IDLE.
  - All w_* outputs 0.
  - dreq_valid=0, stallM=0.
- Memory op: memop = e_valid & (e_memread | e_memwrite) & ~misalign.
- Misalignment:
  - Half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
  - A misaligned op issues no request, does not stall, and sets w_misalign=1 with w_regwrite=0.
- FSM states: IDLE, ADDR (request presented, awaiting addr_ok), DATA (accepted, awaiting data_ok).
  - IDLE: memop raises dreq_valid combinationally the same cycle.
    - addr_ok & data_ok -> complete, stay IDLE.
    - addr_ok only -> DATA.
    - neither -> ADDR.
  - ADDR: hold dreq_valid and all dreq fields stable.
    - addr_ok & data_ok -> IDLE, complete.
    - addr_ok -> DATA.
  - DATA: dreq_valid=0.
    - data_ok -> IDLE, complete.
- Completion occurs in the cycle data_ok is seen in a valid state. data_ok while IDLE with no memop is ignored.
- stallM = memop-in-flight and not completing this cycle:
  - IDLE: memop & ~(addr_ok & data_ok).
  - ADDR: ~(addr_ok & data_ok).
  - DATA: ~data_ok.
- Request fields:
  - dreq_addr = e_aluout.
  - dreq_size = e_funct3[1:0].
  - Store strobe: size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0].
  - dreq_data = e_writedata shifted left by 8*addr[2:0].
  - Loads: strobe=0.
- Load format:
  - Shift dresp_data right by 8*addr[2:0] and take the size.
  - Sign-extend when funct3[2]=0; zero-extend when funct3[2]=1 (LBU/LHU/LWU).
  - memdata is combinational from dresp_data; valid only in the completion cycle. Otherwise drives the last captured load value.
- MEM/WB register:
  - Loads when stallM=0: w_valid=e_valid, w_result=(e_memtoreg ? memdata : e_aluout), plus the other fields.
  - When stallM=1, w_valid is loaded 0 (bubble) and the other w_* hold.
- Latency:
  - Non-memory op: 1 cycle to w_*.
  - Memory op: 1 cycle after completion.
- Reset mid-transaction: FSM to IDLE, request dropped; a late data_ok after reset is ignored.
- Upstream keeps e_* constant while stallM=1; the block relies on this and holds no copy.

Test Plan:
- ALU op: e_aluout=0x1234, regwrite, dst=5 -> next cycle w_valid=1, w_result=0x1234, w_dst=5; dreq_valid never 1.
- LB at addr 0x1003, dresp_data=0x00000000_80000000, addr_ok&data_ok same cycle:
  - stallM=0, strobe=0, size=0.
  - w_result=0xFFFF_FFFF_FFFF_FF80.
  - The LBU variant gives 0x80.
- SW at 0x2004, data 0xDEADBEEF:
  - dreq_strobe=0xF0, dreq_data=0xDEADBEEF_00000000.
  - addr_ok delayed 2 cycles and data_ok 1 cycle later -> stallM high 3 cycles, dreq fields stable, w_valid=0 during stall.
- LD at 0x3000:
  - addr_ok cycle 0 -> DATA state, dreq_valid=0.
  - data_ok cycle 4 with 0x0123456789ABCDEF -> memdata matches that cycle; w_result next cycle.
- LH at 0x4001 -> no request, stallM=0, w_misalign=1, w_regwrite=0.
- resetn pulled low while in DATA -> all w_*=0 and dreq_valid=0 immediately; subsequent data_ok is ignored and w_valid stays 0.
